// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and flag controller for a single-clock FIFO.
// Qualifies producer and consumer requests and drives the storage array's strobes and addresses.
module fifo_ctrl #(
  parameter int ADDR_WIDTH    = 5,
  parameter int AFULL_THRESH  = 28,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  i_Wr_Req,
  input  logic                  i_Rd_Req,
  input  logic                  i_Clr,
  input  logic                  i_Err_Clr,
  output logic                  o_Wr_En,
  output logic [ADDR_WIDTH-1:0] o_Wr_Addr,
  output logic                  o_Rd_En,
  output logic [ADDR_WIDTH-1:0] o_Rd_Addr,
  output logic                  o_Full,
  output logic                  o_Empty,
  output logic                  o_Almost_Full,
  output logic                  o_Almost_Empty,
  output logic [ADDR_WIDTH:0]   o_Count,
  output logic                  o_Overflow,
  output logic                  o_Underflow
);

  localparam logic [ADDR_WIDTH:0] AF_TH = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_TH = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

  logic [ADDR_WIDTH:0] wptr;
  logic [ADDR_WIDTH:0] rptr;
  logic [ADDR_WIDTH:0] count;
  logic                wr_acc;
  logic                rd_acc;
  logic                ovf_set;
  logic                udf_set;

  // Flags decode registered pointers/count only; the extra pointer bit tells full from empty.
  assign o_Full         = (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]) &&
                          (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]);
  assign o_Empty        = (wptr == rptr);
  assign o_Almost_Full  = (count >= AF_TH);
  assign o_Almost_Empty = (count <= AE_TH);
  assign o_Count        = count;
  assign o_Wr_Addr      = wptr[ADDR_WIDTH-1:0];
  assign o_Rd_Addr      = rptr[ADDR_WIDTH-1:0];

  assign wr_acc  = i_Wr_Req & ~o_Full  & ~i_Clr;
  assign rd_acc  = i_Rd_Req & ~o_Empty & ~i_Clr;
  assign ovf_set = i_Wr_Req & o_Full  & ~i_Clr;
  assign udf_set = i_Rd_Req & o_Empty & ~i_Clr;
  assign o_Wr_En = wr_acc;
  assign o_Rd_En = rd_acc;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (i_Clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A new error event in the same cycle as i_Err_Clr keeps the flag set.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      o_Overflow  <= 1'b0;
      o_Underflow <= 1'b0;
    end else begin
      o_Overflow  <= ovf_set | (o_Overflow  & ~i_Err_Clr);
      o_Underflow <= udf_set | (o_Underflow & ~i_Err_Clr);
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: occupancy-level reference model checked every cycle, plus directed literal checks.
module tb_fifo_ctrl;
  localparam int AW  = 5;
  localparam int DEP = 32;
  localparam int AF  = 28;
  localparam int AE  = 4;

  logic          clk = 1'b0;
  logic          RST = 1'b0;
  logic          i_Wr_Req = 1'b0, i_Rd_Req = 1'b0, i_Clr = 1'b0, i_Err_Clr = 1'b0;
  logic          o_Wr_En, o_Rd_En, o_Full, o_Empty, o_Almost_Full, o_Almost_Empty;
  logic          o_Overflow, o_Underflow;
  logic [AW-1:0] o_Wr_Addr, o_Rd_Addr;
  logic [AW:0]   o_Count;

  int n_cmp  = 0;
  int n_fail = 0;

  fifo_ctrl #(.ADDR_WIDTH(AW), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) dut (
    .clk(clk), .RST(RST), .i_Wr_Req(i_Wr_Req), .i_Rd_Req(i_Rd_Req), .i_Clr(i_Clr),
    .i_Err_Clr(i_Err_Clr), .o_Wr_En(o_Wr_En), .o_Wr_Addr(o_Wr_Addr), .o_Rd_En(o_Rd_En),
    .o_Rd_Addr(o_Rd_Addr), .o_Full(o_Full), .o_Empty(o_Empty), .o_Almost_Full(o_Almost_Full),
    .o_Almost_Empty(o_Almost_Empty), .o_Count(o_Count), .o_Overflow(o_Overflow),
    .o_Underflow(o_Underflow)
  );

  always #5 clk = ~clk;

  // Model: total writes since clear (mod 64) and occupancy; read position is derived from them.
  int   m_w = 0;
  int   m_cnt = 0;
  logic m_ovf = 1'b0, m_udf = 1'b0;
  logic m_wa, m_ra;
  assign m_wa = i_Wr_Req && !i_Clr && (m_cnt < DEP);
  assign m_ra = i_Rd_Req && !i_Clr && (m_cnt > 0);

  always @(posedge clk or negedge RST) begin
    if (!RST) begin
      m_w <= 0; m_cnt <= 0; m_ovf <= 1'b0; m_udf <= 1'b0;
    end else begin
      if (i_Clr) begin
        m_w <= 0; m_cnt <= 0;
      end else begin
        m_w   <= (m_w + int'(m_wa)) % (2*DEP);
        m_cnt <= m_cnt + int'(m_wa) - int'(m_ra);
      end
      m_ovf <= (i_Wr_Req && !i_Clr && m_cnt == DEP) ? 1'b1 : (i_Err_Clr ? 1'b0 : m_ovf);
      m_udf <= (i_Rd_Req && !i_Clr && m_cnt == 0)   ? 1'b1 : (i_Err_Clr ? 1'b0 : m_udf);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (RST) begin
      chk("wr_en",   int'(o_Wr_En),        int'(m_wa));
      chk("rd_en",   int'(o_Rd_En),        int'(m_ra));
      chk("wr_addr", int'(o_Wr_Addr),      m_w % DEP);
      chk("rd_addr", int'(o_Rd_Addr),      (m_w - m_cnt + 2*DEP) % DEP);
      chk("count",   int'(o_Count),        m_cnt);
      chk("full",    int'(o_Full),         int'(m_cnt == DEP));
      chk("empty",   int'(o_Empty),        int'(m_cnt == 0));
      chk("afull",   int'(o_Almost_Full),  int'(m_cnt >= AF));
      chk("aempty",  int'(o_Almost_Empty), int'(m_cnt <= AE));
      chk("ovf",     int'(o_Overflow),     int'(m_ovf));
      chk("udf",     int'(o_Underflow),    int'(m_udf));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic r, input logic c, input logic e);
    i_Wr_Req = w; i_Rd_Req = r; i_Clr = c; i_Err_Clr = e;
  endtask

  task automatic clear_then_fill(input int n);
    drive(0, 0, 1, 0); step();
    drive(1, 0, 0, 0);
    repeat (n) step();
    drive(0, 0, 0, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count"}, int'(o_Count), 0);
    chk({tag, "_empty"}, int'(o_Empty), 1);
    chk({tag, "_full"},  int'(o_Full), 0);
    chk({tag, "_aempty"}, int'(o_Almost_Empty), 1);
    chk({tag, "_afull"}, int'(o_Almost_Full), 0);
    chk({tag, "_waddr"}, int'(o_Wr_Addr), 0);
    chk({tag, "_raddr"}, int'(o_Rd_Addr), 0);
    chk({tag, "_ovf"},   int'(o_Overflow), 0);
    chk({tag, "_udf"},   int'(o_Underflow), 0);
  endtask

  initial begin
    #3;
    chk_reset_vals("rst");
    #20;
    @(posedge clk); #1;
    RST = 1'b1;

    // Fill 32 with no reads.
    drive(1, 0, 0, 0);
    for (int i = 0; i < DEP; i++) begin
      chk("fill_waddr", int'(o_Wr_Addr), i);
      chk("fill_afull", int'(o_Almost_Full), int'(i >= AF));
      step();
    end
    chk("full_lit", int'(o_Full), 1);
    chk("count32_lit", int'(o_Count), 32);
    #2;
    chk("wr_en_full_lit", int'(o_Wr_En), 0);
    step();
    chk("ovf_lit", int'(o_Overflow), 1);

    // Simultaneous write and read from full.
    drive(1, 1, 0, 0);
    #2;
    chk("full_both_rd_lit", int'(o_Rd_En), 1);
    chk("full_both_wr_lit", int'(o_Wr_En), 0);
    step();
    drive(0, 0, 0, 0);
    chk("count31_lit", int'(o_Count), 31);
    chk("ovf_kept_lit", int'(o_Overflow), 1);

    // Drain, underflow and error-clear priority.
    drive(0, 1, 0, 0);
    repeat (31) step();
    chk("empty_lit", int'(o_Empty), 1);
    #2;
    chk("rd_en_empty_lit", int'(o_Rd_En), 0);
    step();
    chk("udf_lit", int'(o_Underflow), 1);
    drive(0, 1, 0, 1); step();
    chk("udf_errclr_set_lit", int'(o_Underflow), 1);
    drive(0, 0, 0, 1); step();
    chk("udf_cleared_lit", int'(o_Underflow), 0);
    chk("ovf_cleared_lit", int'(o_Overflow), 0);

    // Steady write+read at count 5 across two wraps.
    clear_then_fill(5);
    drive(1, 1, 0, 0);
    for (int i = 0; i < 70; i++) begin
      step();
      chk("wrap_count", int'(o_Count), 5);
      chk("wrap_diff", (int'(o_Wr_Addr) - int'(o_Rd_Addr) + DEP) % DEP, 5);
    end
    chk("wrap_waddr_lit", int'(o_Wr_Addr), (5 + 70) % 32);

    // Clear beats a write; error flags untouched.
    clear_then_fill(0);
    drive(0, 1, 0, 0); step();
    clear_then_fill(17);
    chk("count17_lit", int'(o_Count), 17);
    drive(1, 0, 1, 0);
    #2;
    chk("clr_wr_en_lit", int'(o_Wr_En), 0);
    step();
    drive(0, 0, 0, 0);
    chk("clr_count_lit", int'(o_Count), 0);
    chk("clr_empty_lit", int'(o_Empty), 1);
    chk("clr_waddr_lit", int'(o_Wr_Addr), 0);
    chk("clr_raddr_lit", int'(o_Rd_Addr), 0);
    chk("clr_udf_lit", int'(o_Underflow), 1);

    // Asynchronous reset mid-burst.
    clear_then_fill(10);
    drive(1, 0, 0, 0);
    #2;
    RST = 1'b0;
    #1;
    chk_reset_vals("arst");
    step();
    drive(0, 0, 0, 0);
    RST = 1'b1;

    // Randomized traffic with alternating bias so both ends are reached.
    for (int i = 0; i < 2000; i++) begin
      int pw;
      pw = ((i / 100) % 2 == 0) ? 75 : 25;
      drive($urandom_range(0, 99) < pw, $urandom_range(0, 99) < (100 - pw),
            $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5);
      step();
    end
    drive(0, 0, 0, 0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Pointer and flag controller for the synchronous single-clock FIFO.
- Accepts write/read requests and qualifies them against full/empty.
- Drives the memory write/read enables and addresses, and keeps occupancy count, almost-full/almost-empty flags and sticky overflow/underflow errors.
- Sits between the producer/consumer request logic and the dual-port storage array.

Parameters:
- ADDR_WIDTH, 5, storage address width; DEPTH = 2**ADDR_WIDTH entries (32).
- AFULL_THRESH, 28, o_Almost_Full asserts when count >= this value; legal range 1..DEPTH.
- AEMPTY_THRESH, 4, o_Almost_Empty asserts when count <= this value; legal range 0..DEPTH-1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-low reset.
- i_Wr_Req  input  1  producer write request.
- i_Rd_Req  input  1  consumer read request.
- i_Clr  input  1  synchronous flush of pointers and count.
- i_Err_Clr  input  1  synchronous clear of sticky error flags.
- o_Wr_En  output  1  memory write strobe (accepted write).
- o_Wr_Addr  output  ADDR_WIDTH  memory write address.
- o_Rd_En  output  1  memory read strobe (accepted read).
- o_Rd_Addr  output  ADDR_WIDTH  memory read address.
- o_Full  output  1  count == DEPTH.
- o_Empty  output  1  count == 0.
- o_Almost_Full  output  1  count >= AFULL_THRESH.
- o_Almost_Empty  output  1  count <= AEMPTY_THRESH.
- o_Count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- o_Overflow  output  1  sticky: write requested while full and not accepted.
- o_Underflow  output  1  sticky: read requested while empty and not accepted.

Behaviour:
- Reset (RST low, async):
  - Write and read pointers, count, o_Overflow and o_Underflow all go to 0.
  - Resulting outputs: o_Empty=1, o_Full=0, o_Almost_Empty=1, o_Almost_Full=0, o_Wr_Addr=o_Rd_Addr=0.
  - Reset mid-operation discards all contents immediately.
- Pointers:
  - Internal wptr and rptr are ADDR_WIDTH+1 bits; the MSB is the wrap bit.
  - Each increments by 1 per accepted operation and wraps modulo 2**(ADDR_WIDTH+1).
  - o_Wr_Addr = wptr[ADDR_WIDTH-1:0]; o_Rd_Addr = rptr[ADDR_WIDTH-1:0].
- Full/empty decode:
  - Full = lower bits equal and MSBs differ.
  - Empty = pointers identical.
  - Full and empty must agree with o_Count at all times.
- Acceptance (combinational, same cycle):
  - wr_acc = i_Wr_Req & ~o_Full & ~i_Clr.
  - rd_acc = i_Rd_Req & ~o_Empty & ~i_Clr.
  - o_Wr_En = wr_acc; o_Rd_En = rd_acc. Memory samples the write at the same edge that advances wptr.
- Simultaneous write and read:
  - When full: read accepted, write rejected; overflow sets. Count becomes DEPTH-1.
  - When empty: write accepted, read rejected; underflow sets. Count becomes 1.
  - Otherwise both are accepted and count is unchanged.
- Count update per edge: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither; never leaves 0..DEPTH.
- Flags: o_Full, o_Empty, o_Almost_Full and o_Almost_Empty decode registered state only. There is no combinational path from requests to flags. Each flag reflects an operation one cycle after its accepting edge.
- Sticky errors:
  - o_Overflow sets at the edge after i_Wr_Req & o_Full & ~i_Clr.
  - o_Underflow sets at the edge after i_Rd_Req & o_Empty & ~i_Clr.
  - i_Err_Clr clears both; a set event in the same cycle as i_Err_Clr wins (flag stays 1).
  - i_Clr does not affect the error flags.
- Clear: i_Clr high takes priority over all requests.
  - o_Wr_En and o_Rd_En are forced 0 in that cycle.
  - Pointers and count go to 0 at the next edge.
- Wrap-around: after 2*DEPTH accepted writes and reads, pointers return to 0 with no flag glitch.

Test Plan:
- Reset, then 32 writes with no reads -> o_Wr_Addr steps 0..31; o_Almost_Full rises the cycle after the 28th accept; o_Full=1 and o_Count=32 after the 32nd; a 33rd request gives o_Wr_En=0 and o_Overflow=1 next cycle.
- From full, drive i_Wr_Req and i_Rd_Req together for 1 cycle -> o_Rd_En=1, o_Wr_En=0, o_Count=31, o_Overflow=1.
- From empty, read request -> o_Rd_En=0, o_Underflow=1; then i_Err_Clr with a second underflow request in the same cycle -> o_Underflow stays 1; i_Err_Clr alone -> 0.
- Continuous simultaneous write and read at count=5 for 70 cycles -> o_Count stays 5; both addresses wrap 31->0 twice; o_Wr_Addr - o_Rd_Addr == 5 mod 32 throughout.
- At count=17 assert i_Clr together with i_Wr_Req -> o_Wr_En=0; next cycle o_Count=0, o_Empty=1, both addresses 0; error flags unchanged.
- Drop RST asynchronously mid-burst at count=10 -> outputs take reset values before the next clock edge.
